// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader.
package mips_boot_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned BYTE_CNT_W     = 2;

    localparam logic [1:0] RAM_SEL_WORD = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } boot_state_e;

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(input boot_state_e s);
        return (s == S_IDLE) || (s == S_LEN) || (s == S_LOAD) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/mips_boot_loader_if.sv
// Byte stream in, RAM write port out. master = loader side, slave = environment side.
interface mips_boot_loader_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic [7:0]               RX_DATA;
    logic                     RX_VALID;
    logic                     RX_READY;
    logic [ADDRESS_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0]    MEM_DATA;
    logic                     MEM_WS;
    logic [1:0]               RAM_SEL;

    modport master (
        input  RX_DATA, RX_VALID,
        output RX_READY, MEM_ADDR, MEM_DATA, MEM_WS, RAM_SEL
    );

    modport slave (
        output RX_DATA, RX_VALID,
        input  RX_READY, MEM_ADDR, MEM_DATA, MEM_WS, RAM_SEL
    );
endinterface

// File: rtl/boot_word_assembler.sv
// Little-endian byte-to-word assembler: holds the first three bytes of a
// word and presents the full word combinationally with the fourth byte.
module boot_word_assembler
    import mips_boot_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              accept_i,
    output logic [WORD_W-1:0] word_c_o,
    output logic              word_done_c_o
);

    localparam int unsigned HOLD_W = WORD_W - BYTE_W;

    logic [HOLD_W-1:0]     shreg_q, shreg_d;
    logic [BYTE_CNT_W-1:0] cnt_q;

    // Newest byte enters at the top so the first byte ends up least significant.
    always_comb begin
        shreg_d       = {byte_i, shreg_q[HOLD_W-1:BYTE_W]};
        word_c_o      = {byte_i, shreg_q};
        word_done_c_o = accept_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    end

    // Shift register and byte counter; counter wraps after each word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (accept_i) begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + BYTE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// Program loader: length-prefixed byte stream -> 32-bit RAM writes, CPU held
// in reset until the image is in. Optional trailing XOR checksum when
// BOOT_CHECKSUM_EN is defined.
module mips_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int unsigned            ADDRESS_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned            MAX_WORDS     = 1024
) (
    input  logic                CLK,
    input  logic                RST,
    mips_boot_loader_if.master  bus,
    output logic                CPU_RST,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

    boot_state_e state_q, state_d;

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WORD_W-1:0]        count_q, count_d;
    logic                     mem_ws_q, mem_ws_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_data_q, mem_data_d;
    logic                     cpu_rst_q, cpu_rst_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
    logic [WORD_W-1:0]        xor_q, xor_d;
`endif

    logic              rx_ready_c;
    logic              accept_c;
    logic [WORD_W-1:0] word_c;
    logic              word_done_c;
    logic              last_word_c;

    // Ready is decoded from state and forced low while reset is applied.
    always_comb begin
        rx_ready_c  = accepts_bytes(state_q) && !RST;
        accept_c    = bus.RX_VALID && rx_ready_c;
        last_word_c = (WORD_W'(idx_q) + WORD_W'(1)) == count_q;
    end

    boot_word_assembler u_asm (
        .clk_i         (CLK),
        .rst_i         (RST),
        .byte_i        (bus.RX_DATA),
        .accept_i      (accept_c),
        .word_c_o      (word_c),
        .word_done_c_o (word_done_c)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (word_done_c) begin
                    if (word_c == '0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else if (word_c > WORD_W'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (word_done_c) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_word_c) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_CHECK: begin
`ifdef BOOT_CHECKSUM_EN
                if (word_done_c) begin
                    state_d = (word_c == xor_q) ? S_DONE : S_ERR;
                end
`else
                state_d = S_ERR;
`endif
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; status follows the next state so
    // every output is a flop.
    always_comb begin
        idx_d      = idx_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
`ifdef BOOT_CHECKSUM_EN
        xor_d      = xor_q;
`endif

        if ((state_q == S_LEN) && word_done_c) begin
            count_d = word_c;
        end

        if ((state_q == S_LOAD) && word_done_c) begin
            mem_addr_d = BASE_ADDR + (ADDRESS_WIDTH'(idx_q) << 2);
            mem_data_d = DATA_WIDTH'(word_c);
`ifdef BOOT_CHECKSUM_EN
            xor_d      = xor_q ^ word_c;
`endif
        end

        if (state_q == S_WRITE) begin
            idx_d = idx_q + IDX_W'(1);
        end

        mem_ws_d  = (state_d == S_WRITE);
        cpu_rst_d = (state_d != S_DONE);
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q      <= '0;
            count_q    <= '0;
            mem_ws_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            idx_q      <= idx_d;
            count_q    <= count_d;
            mem_ws_q   <= mem_ws_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef BOOT_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    // Port drive.
    always_comb begin
        bus.RX_READY = rx_ready_c;
        bus.MEM_ADDR = mem_addr_q;
        bus.MEM_DATA = mem_data_q;
        bus.MEM_WS   = mem_ws_q;
        bus.RAM_SEL  = RAM_SEL_WORD;
        CPU_RST      = cpu_rst_q;
        BUSY         = busy_q;
        DONE         = done_q;
        ERR          = err_q;
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader. Two instances (BASE_ADDR 0 and 0x100)
// see the same byte stream; checksum cases are built when BOOT_CHECKSUM_EN
// is defined.
module tb_mips_boot_loader;

    logic       CLK;
    logic       RST;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic cpu_rst0, busy0, done0, err0;
    logic cpu_rst1, busy1, done1, err1;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa0[$];
    logic [31:0] wd0[$];
    logic [31:0] wa1[$];
    logic [31:0] wd1[$];
    int mark0;
    int mark1;

    mips_boot_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    mips_boot_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    assign bus0.RX_DATA  = rx_data;
    assign bus0.RX_VALID = rx_valid;
    assign bus1.RX_DATA  = rx_data;
    assign bus1.RX_VALID = rx_valid;

    mips_boot_loader #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .MAX_WORDS(1024)
    ) dut0 (
        .CLK(CLK), .RST(RST), .bus(bus0),
        .CPU_RST(cpu_rst0), .BUSY(busy0), .DONE(done0), .ERR(err0)
    );

    mips_boot_loader #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h100), .MAX_WORDS(1024)
    ) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1),
        .CPU_RST(cpu_rst1), .BUSY(busy1), .DONE(done1), .ERR(err1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Log every RAM write seen at the clock edge that commits it.
    always @(posedge CLK) begin
        if (bus0.MEM_WS === 1'b1) begin
            wa0.push_back(bus0.MEM_ADDR);
            wd0.push_back(bus0.MEM_DATA);
        end
        if (bus1.MEM_WS === 1'b1) begin
            wa1.push_back(bus1.MEM_ADDR);
            wd1.push_back(bus1.MEM_DATA);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        rx_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        mark0 = wa0.size();
        mark1 = wa1.size();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        int waited;
        if (gap) begin
            n = int'($urandom_range(0, 3));
            repeat (n) begin
                @(posedge CLK); #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (waited < 100) begin
            @(negedge CLK);
            if (bus0.RX_READY === 1'b1) break;
            waited++;
        end
        if (waited >= 100) begin
            check("rx_ready_wait", 64'(bus0.RX_READY), 64'h1);
        end else begin
            @(posedge CLK); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[7:0], gap);
            v = v >> 8;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        RST      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        mark0    = 0;
        mark1    = 0;

        // ---- reset values
        @(posedge CLK); #1;
        check("rst_rx_ready", 64'(bus0.RX_READY), 64'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("rst_mem_ws",   64'(bus0.MEM_WS),   64'h0);
        check("rst_mem_addr", 64'(bus0.MEM_ADDR), 64'h0);
        check("rst_mem_data", 64'(bus0.MEM_DATA), 64'h0);
        check("rst_ram_sel",  64'(bus0.RAM_SEL),  64'h0);
        check("rst_cpu_rst",  64'(cpu_rst0),      64'h1);
        check("rst_busy",     64'(busy0),         64'h0);
        check("rst_done",     64'(done0),         64'h0);
        check("rst_err",      64'(err0),          64'h0);
        check("idle_rx_ready", 64'(bus0.RX_READY), 64'h1);

        // ---- two-word image
        do_reset();
        send_word(32'h0000_0002, 1'b0);
        check("t1_busy_len", 64'(busy0), 64'h1);
        send_word(32'hDEAD_BEEF, 1'b0);
        check("t1_ws0",    64'(bus0.MEM_WS),   64'h1);
        check("t1_addr0",  64'(bus0.MEM_ADDR), 64'h0);
        check("t1_addr0b", 64'(bus1.MEM_ADDR), 64'h100);
        check("t1_data0",  64'(bus0.MEM_DATA), 64'hDEAD_BEEF);
        check("t1_rdy_wr", 64'(bus0.RX_READY), 64'h0);
        send_word(32'h1234_5678, 1'b0);
        check("t1_ws1",    64'(bus0.MEM_WS),   64'h1);
        check("t1_addr1",  64'(bus0.MEM_ADDR), 64'h4);
        check("t1_data1",  64'(bus0.MEM_DATA), 64'h1234_5678);
        check("t1_done_early", 64'(done0), 64'h0);
        idle(1);
        check("t1_ws_off", 64'(bus0.MEM_WS), 64'h0);
`ifdef BOOT_CHECKSUM_EN
        check("t1_check_busy", 64'(busy0), 64'h1);
        check("t1_check_rdy",  64'(bus0.RX_READY), 64'h1);
        send_word(32'hCC99_E897, 1'b0);
`endif
        check("t1_done",    64'(done0),    64'h1);
        check("t1_cpu_rst", 64'(cpu_rst0), 64'h0);
        check("t1_busy",    64'(busy0),    64'h0);
        check("t1_rdy_done", 64'(bus0.RX_READY), 64'h0);
        idle(3);
        check("t1_nwrites", 64'(wa0.size() - mark0), 64'h2);
        check("t1_w0a", 64'(wa0[mark0]),     64'h0);
        check("t1_w0d", 64'(wd0[mark0]),     64'hDEAD_BEEF);
        check("t1_w1a", 64'(wa0[mark0 + 1]), 64'h4);
        check("t1_w1d", 64'(wd0[mark0 + 1]), 64'h1234_5678);
        check("t1_cpu_rst_hold", 64'(cpu_rst0), 64'h0);

        // ---- empty image
        do_reset();
        send_word(32'h0000_0000, 1'b0);
`ifdef BOOT_CHECKSUM_EN
        check("t2_check_busy", 64'(busy0), 64'h1);
        send_word(32'h0000_0000, 1'b0);
`endif
        check("t2_done",    64'(done0),    64'h1);
        check("t2_cpu_rst", 64'(cpu_rst0), 64'h0);
        check("t2_err",     64'(err0),     64'h0);
        idle(2);
        check("t2_nwrites", 64'(wa0.size() - mark0), 64'h0);

        // ---- count MAX_WORDS+1 rejected
        do_reset();
        send_word(32'h0000_0401, 1'b0);
        check("t3_err",      64'(err0),           64'h1);
        check("t3_cpu_rst",  64'(cpu_rst0),       64'h1);
        check("t3_rdy",      64'(bus0.RX_READY),  64'h0);
        check("t3_busy",     64'(busy0),          64'h0);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        idle(4);
        rx_valid = 1'b0;
        check("t3_err_hold", 64'(err0),     64'h1);
        check("t3_cpu_hold", 64'(cpu_rst0), 64'h1);
        check("t3_done",     64'(done0),    64'h0);
        check("t3_nwrites",  64'(wa0.size() - mark0), 64'h0);

        // ---- count exactly MAX_WORDS accepted
        do_reset();
        send_word(32'h0000_0400, 1'b0);
        check("t4_err",  64'(err0),          64'h0);
        check("t4_busy", 64'(busy0),         64'h1);
        check("t4_rdy",  64'(bus0.RX_READY), 64'h1);

        // ---- three words with random gaps
        do_reset();
        send_word(32'h0000_0003, 1'b1);
        send_word(32'hA5A5_A5A5, 1'b1);
        send_word(32'h0123_4567, 1'b1);
        send_word(32'h89AB_CDEF, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        idle(1);
        send_word(32'h2D2D_2D2D, 1'b1);
`endif
        idle(2);
        check("t5_done",    64'(done0), 64'h1);
        check("t5_done_b",  64'(done1), 64'h1);
        check("t5_nwrites", 64'(wa1.size() - mark1), 64'h3);
        check("t5_w0a", 64'(wa1[mark1]),     64'h100);
        check("t5_w0d", 64'(wd1[mark1]),     64'hA5A5_A5A5);
        check("t5_w1a", 64'(wa1[mark1 + 1]), 64'h104);
        check("t5_w1d", 64'(wd1[mark1 + 1]), 64'h0123_4567);
        check("t5_w2a", 64'(wa1[mark1 + 2]), 64'h108);
        check("t5_w2d", 64'(wd1[mark1 + 2]), 64'h89AB_CDEF);
        check("t5_w2a_base0", 64'(wa0[mark0 + 2]), 64'h8);

        // ---- reset in the middle of a load, then a one-word image
        do_reset();
        send_word(32'h0000_0003, 1'b0);
        send_byte(8'hAA, 1'b0);
        check("t6_busy_mid", 64'(busy0), 64'h1);
        RST = 1'b1;
        #1;
        check("t6_rdy_in_rst", 64'(bus0.RX_READY), 64'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("t6_busy",    64'(busy0),          64'h0);
        check("t6_cpu_rst", 64'(cpu_rst0),       64'h1);
        check("t6_rdy",     64'(bus0.RX_READY),  64'h1);
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        check("t6_ws",   64'(bus0.MEM_WS),   64'h1);
        check("t6_addr", 64'(bus0.MEM_ADDR), 64'h0);
        check("t6_data", 64'(bus0.MEM_DATA), 64'hCAFE_F00D);
`ifdef BOOT_CHECKSUM_EN
        idle(1);
        send_word(32'hCAFE_F00D, 1'b0);
`endif
        idle(2);
        check("t6_done",    64'(done0), 64'h1);
        check("t6_nwrites", 64'(wa0.size() - mark0), 64'h1);
        check("t6_w0a",     64'(wa1[mark1]), 64'h100);
        check("t6_w0d",     64'(wd1[mark1]), 64'hCAFE_F00D);

`ifdef BOOT_CHECKSUM_EN
        // ---- checksum match
        do_reset();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h0000_FFFF, 1'b0);
        send_word(32'hFFFF_0000, 1'b0);
        idle(1);
        send_word(32'hFFFF_FFFF, 1'b0);
        check("t7_done",    64'(done0),    64'h1);
        check("t7_err",     64'(err0),     64'h0);
        check("t7_cpu_rst", 64'(cpu_rst0), 64'h0);

        // ---- checksum mismatch
        do_reset();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h0000_FFFF, 1'b0);
        send_word(32'hFFFF_0000, 1'b0);
        idle(1);
        send_word(32'h0000_0000, 1'b0);
        check("t8_err",     64'(err0),     64'h1);
        check("t8_done",    64'(done0),    64'h0);
        idle(2);
        check("t8_cpu_rst", 64'(cpu_rst0), 64'h1);
        check("t8_nwrites", 64'(wa0.size() - mark0), 64'h2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_boot_loader.md
# mips_boot_loader

Program loader upstream of the MIPS RAM. It receives a program image as an 8-bit valid/ready byte stream and assembles the bytes into 32-bit little-endian words. It writes those words into RAM through the same address, data, write-strobe and select signals the CPU uses. The CPU is held in reset until the image has been loaded completely.

## Interface
- ADDRESS_WIDTH, 32, RAM address width (byte addressing)
- DATA_WIDTH, 32, RAM word width; fixed at 32 for this block
- BASE_ADDR, 0, byte address of the first program word
- MAX_WORDS, 1024, largest accepted word count
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- RX_DATA  in  8  incoming image byte
- RX_VALID  in  1  RX_DATA is valid
- RX_READY  out  1  loader accepts a byte this cycle
- MEM_ADDR  out  ADDRESS_WIDTH  RAM write address
- MEM_DATA  out  DATA_WIDTH  RAM write data
- MEM_WS  out  1  RAM write strobe
- RAM_SEL  out  2  RAM access size; always 2'b00 (word)
- CPU_RST  out  1  reset to the CPU; high until the load completes
- BUSY  out  1  a load is in progress
- DONE  out  1  sticky; image loaded successfully
- ERR  out  1  sticky; load aborted

## Operation
- Image format:
  - 4-byte little-endian word count N.
  - Then N words, each sent as 4 bytes, least-significant byte first.
- A byte is accepted only on a cycle where RX_VALID && RX_READY.
- States:
  - IDLE: waits for the first byte; accepting it moves to LEN.
  - LEN: collects the 4 count bytes.
    - N=0 → DONE.
    - N>MAX_WORDS → ERR.
    - Otherwise → LOAD.
  - LOAD: collects 4 bytes into one word. The 4th byte → WRITE.
  - WRITE: one cycle.
    - Outputs MEM_WS=1, MEM_ADDR=BASE_ADDR+4*idx, MEM_DATA=the assembled word.
    - Then idx++.
    - If idx+1==N → DONE (or CHECK when checksum is enabled); otherwise → LOAD.
  - DONE and ERR are terminal. Only RST leaves them.
- RX_READY=1 in IDLE, LEN, LOAD and CHECK; 0 in WRITE, DONE and ERR.
- Bytes offered while RX_READY=0 are not consumed. The producer holds them.
- idx is clog2(MAX_WORDS+1) bits wide and never wraps, because N is bounded by MAX_WORDS.
- MEM_ADDR arithmetic is modulo 2^ADDRESS_WIDTH.
- BUSY=1 in every state except IDLE, DONE and ERR.

## Timing
- Reset values:
  - RX_READY=0 during the reset cycle, then 1 in IDLE.
  - MEM_WS=0, MEM_ADDR=0, MEM_DATA=0, RAM_SEL=2'b00.
  - CPU_RST=1, BUSY=0, DONE=0, ERR=0.
- All outputs are registered, except RX_READY, which is decoded from the state register.
- Latency: MEM_WS is high the cycle after the 4th byte of a word is accepted. The RAM write happens at the end of that cycle.
- Throughput: at most one word per 5 cycles (4 byte cycles plus 1 WRITE cycle).
- DONE rises the cycle after the final WRITE cycle (or after CHECK resolves). CPU_RST falls in the same cycle and stays low.
- In ERR, CPU_RST stays 1 permanently.
- Reset in the middle of a load:
  - Returns the block to IDLE the next cycle and clears idx and the partial word.
  - Raises CPU_RST and cancels any pending write.
  - RAM contents are left as they are.
- RX_VALID may drop between bytes. Gaps of any length are tolerated.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - After the N words, a 4-byte little-endian checksum is accepted in state CHECK.
  - The checksum is the XOR of all N data words.
  - Match → DONE; mismatch → ERR. For N=0 the expected value is 0.
- BOOT_CHECKSUM_EN undefined:
  - CHECK state and the XOR register are not built.
  - The final WRITE goes directly to DONE.

## Structure
- Package mips_boot_pkg holds:
  - the state enum (IDLE, LEN, LOAD, WRITE, CHECK, DONE, ERR);
  - RAM_SEL_WORD = 2'b00;
  - BYTES_PER_WORD = 4.
- Sub-module boot_word_assembler holds the byte shift register and the 2-bit byte counter. It outputs a word-complete pulse and is shared by LEN, LOAD and CHECK.

## Test plan
- Stream 02 00 00 00, EF BE AD DE, 78 56 34 12 → two writes: 0xDEADBEEF @0x0 and 0x12345678 @0x4. MEM_WS pulses exactly once per word. DONE=1 and CPU_RST=0 one cycle after the 2nd write.
- Stream 00 00 00 00 → no writes; DONE=1 and CPU_RST=0.
- Count MAX_WORDS+1 → ERR=1, no writes, CPU_RST stays 1, RX_READY=0.
- Toggle RX_VALID randomly 0/1 during a 3-word load with BASE_ADDR=0x100 → writes at 0x100, 0x104, 0x108 with correct data.
- Assert RST after 5 bytes, then stream a 1-word image 0xCAFEF00D → single write of 0xCAFEF00D @BASE_ADDR; no write from the aborted load.
- With BOOT_CHECKSUM_EN: 2 words 0x0000FFFF and 0xFFFF0000 plus checksum 0xFFFFFFFF → DONE. Checksum 0x00000000 → ERR with CPU_RST=1.
